// File: rtl/draw_dispatch_if.sv
// draw_dispatch_if
//  Command channel from the command source into the draw dispatcher.
//  A command is transferred on a clock edge where cmd_valid and cmd_ready
//  are both high.
//  Signals:
//   cmd_valid   source -> dispatcher  command present
//   cmd_ready   dispatcher -> source  command queue has room
//   cmd_opcode  source -> dispatcher  engine select
//   cmd_ax..cy  source -> dispatcher  triangle vertex operands
//   cmd_colour  source -> dispatcher  draw colour
//  Modports: master = command source, slave = dispatcher.
interface draw_dispatch_if #(
    parameter int WIDTH        = 8,
    parameter int COLOUR_WIDTH = 3,
    parameter int OPCODE_WIDTH = 3
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [OPCODE_WIDTH-1:0] cmd_opcode;
    logic [WIDTH-1:0]        cmd_ax;
    logic [WIDTH-1:0]        cmd_ay;
    logic [WIDTH-1:0]        cmd_bx;
    logic [WIDTH-1:0]        cmd_by;
    logic [WIDTH-1:0]        cmd_cx;
    logic [WIDTH-1:0]        cmd_cy;
    logic [COLOUR_WIDTH-1:0] cmd_colour;

    modport master (
        output cmd_valid, cmd_opcode, cmd_ax, cmd_ay, cmd_bx, cmd_by,
               cmd_cx, cmd_cy, cmd_colour,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_ax, cmd_ay, cmd_bx, cmd_by,
               cmd_cx, cmd_cy, cmd_colour,
        output cmd_ready
    );
endinterface

// File: rtl/draw_dispatch.sv
// draw_dispatch
//  Queues draw commands in a small FIFO, issues each one to the draw engine
//  selected by its opcode with a one-cycle start pulse, waits for that
//  engine to report completion, and meanwhile routes the active engine's
//  screen request bundle onto the shared screen interface.
//  Ports:
//   clock, reset        clock and asynchronous active-high reset
//   cmd_bus             command channel (slave side)
//   flush               drop queued commands and clear err_illegal
//   eng_ax..eng_colour  latched operands broadcast to every engine
//   eng_en              one-hot start pulse, one bit per engine
//   eng_done            per-engine completion
//   eng_scr_*           per-engine screen request fields, engine k at [k*W +: W]
//   screen_*            muxed screen request for the active engine
//   new_screen_colour   muxed screen colour for the active engine
//   busy                queue non-empty or a command in flight
//   fifo_level          number of queued commands
//   done_count          completed commands, wraps at 16 bits
//   err_illegal         sticky flag: an opcode with no engine was popped
module draw_dispatch #(
    parameter int WIDTH        = 8,
    parameter int COLOUR_WIDTH = 3,
    parameter int NUM_OPS      = 4,
    parameter int OPCODE_WIDTH = 3,
    parameter int DEPTH        = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    draw_dispatch_if.slave                  cmd_bus,
    input  logic                            flush,
    output logic [WIDTH-1:0]                eng_ax,
    output logic [WIDTH-1:0]                eng_ay,
    output logic [WIDTH-1:0]                eng_bx,
    output logic [WIDTH-1:0]                eng_by,
    output logic [WIDTH-1:0]                eng_cx,
    output logic [WIDTH-1:0]                eng_cy,
    output logic [COLOUR_WIDTH-1:0]         eng_colour,
    output logic [NUM_OPS-1:0]              eng_en,
    input  logic [NUM_OPS-1:0]              eng_done,
    input  logic [NUM_OPS-1:0]              eng_scr_start,
    input  logic [NUM_OPS*COLOUR_WIDTH-1:0] eng_scr_colour,
    input  logic [NUM_OPS*WIDTH-1:0]        eng_scr_xmin,
    input  logic [NUM_OPS*WIDTH-1:0]        eng_scr_ymin,
    input  logic [NUM_OPS*WIDTH-1:0]        eng_scr_xrange,
    input  logic [NUM_OPS*WIDTH-1:0]        eng_scr_yrange,
    output logic                            screen_start,
    output logic [COLOUR_WIDTH-1:0]         new_screen_colour,
    output logic [WIDTH-1:0]                screen_x_min,
    output logic [WIDTH-1:0]                screen_y_min,
    output logic [WIDTH-1:0]                screen_x_range,
    output logic [WIDTH-1:0]                screen_y_range,
    output logic                            busy,
    output logic [$clog2(DEPTH):0]          fifo_level,
    output logic [15:0]                     done_count,
    output logic                            err_illegal
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef struct packed {
        logic [OPCODE_WIDTH-1:0] op;
        logic [WIDTH-1:0]        ax;
        logic [WIDTH-1:0]        ay;
        logic [WIDTH-1:0]        bx;
        logic [WIDTH-1:0]        by;
        logic [WIDTH-1:0]        cx;
        logic [WIDTH-1:0]        cy;
        logic [COLOUR_WIDTH-1:0] colour;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    cmd_t                mem_q [DEPTH];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]       level_q, level_d;
    state_t              state_q;
    cmd_t                cur_q;
    logic [NUM_OPS-1:0]  eng_en_q;
    logic [15:0]         done_count_q;
    logic                err_q;

    cmd_t                entry_in;
    cmd_t                head;
    logic                push;
    logic                pop;
    logic                head_legal;
    logic [NUM_OPS-1:0]  head_onehot;
    logic                done_hit;

    assign cmd_bus.cmd_ready = (level_q != LW'(DEPTH));

    // Flush wins over both push and pop so the queue ends the cycle empty.
    assign push = cmd_bus.cmd_valid && cmd_bus.cmd_ready && !flush;
    assign pop  = (state_q == IDLE) && (level_q != '0) && !flush;
    assign head = mem_q[rd_ptr_q];

    always_comb begin
        entry_in.op     = cmd_bus.cmd_opcode;
        entry_in.ax     = cmd_bus.cmd_ax;
        entry_in.ay     = cmd_bus.cmd_ay;
        entry_in.bx     = cmd_bus.cmd_bx;
        entry_in.by     = cmd_bus.cmd_by;
        entry_in.cx     = cmd_bus.cmd_cx;
        entry_in.cy     = cmd_bus.cmd_cy;
        entry_in.colour = cmd_bus.cmd_colour;
    end

    // Decode the head entry's opcode and the active engine's completion.
    // Loops compare against k rather than indexing, so an out-of-range
    // opcode simply matches nothing.
    always_comb begin
        head_legal  = (32'(head.op) < NUM_OPS);
        head_onehot = '0;
        done_hit    = 1'b0;
        for (int k = 0; k < NUM_OPS; k++) begin
            if (head.op == OPCODE_WIDTH'(k)) head_onehot[k] = 1'b1;
            if (cur_q.op == OPCODE_WIDTH'(k) && eng_done[k]) done_hit = 1'b1;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            level_d = level_q + LW'(push) - LW'(pop);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: an entry is only read once level_q covers it.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= entry_in;
    end

    // Command sequencer. The start pulse is registered on the pop edge so it
    // is high for exactly the ISSUE cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cur_q        <= '0;
            eng_en_q     <= '0;
            done_count_q <= '0;
            err_q        <= 1'b0;
        end else begin
            eng_en_q <= '0;
            if (flush) err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        cur_q <= head;
                        if (head_legal) begin
                            state_q  <= ISSUE;
                            eng_en_q <= head_onehot;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ISSUE: state_q <= WAIT;
                WAIT: begin
                    if (done_hit) begin
                        done_count_q <= done_count_q + 16'd1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Screen mux follows the latched opcode; outputs are zero while idle.
    always_comb begin
        screen_start      = 1'b0;
        new_screen_colour = '0;
        screen_x_min      = '0;
        screen_y_min      = '0;
        screen_x_range    = '0;
        screen_y_range    = '0;
        if (state_q != IDLE) begin
            for (int k = 0; k < NUM_OPS; k++) begin
                if (cur_q.op == OPCODE_WIDTH'(k)) begin
                    screen_start      = eng_scr_start[k];
                    new_screen_colour = eng_scr_colour[k*COLOUR_WIDTH +: COLOUR_WIDTH];
                    screen_x_min      = eng_scr_xmin[k*WIDTH +: WIDTH];
                    screen_y_min      = eng_scr_ymin[k*WIDTH +: WIDTH];
                    screen_x_range    = eng_scr_xrange[k*WIDTH +: WIDTH];
                    screen_y_range    = eng_scr_yrange[k*WIDTH +: WIDTH];
                end
            end
        end
    end

    assign eng_ax      = cur_q.ax;
    assign eng_ay      = cur_q.ay;
    assign eng_bx      = cur_q.bx;
    assign eng_by      = cur_q.by;
    assign eng_cx      = cur_q.cx;
    assign eng_cy      = cur_q.cy;
    assign eng_colour  = cur_q.colour;
    assign eng_en      = eng_en_q;
    assign busy        = (level_q != '0) || (state_q != IDLE);
    assign fifo_level  = level_q;
    assign done_count  = done_count_q;
    assign err_illegal = err_q;

endmodule
